// File: rtl/capture_ctrl.sv
// Sample-buffer capture sequencer: fills pre-trigger history, waits for a trigger,
// collects the post-trigger samples into a circular buffer and reports its layout.
module capture_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              sample_en,
   input  logic [7:0]        data,
   input  logic              trigger_detected,
   input  logic              trig_force,
   input  logic              arm,
   input  logic              abort,
   input  logic [ADDR_W-1:0] pretrig_len,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr
);

   // state     | meaning
   // IDLE      | waiting for arm, no writes
   // FILL      | collecting pre-trigger history, only a forced trigger is honoured
   // WAIT_TRIG | rolling through the buffer until a trigger event
   // POST      | collecting the remaining post-trigger samples
   // DONE      | buffer valid, addresses held until arm or abort
   typedef enum logic [2:0] {IDLE, FILL, WAIT_TRIG, POST, DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] pre_len_q, pre_len_d;
   logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;

   logic              we;
   logic              fill_open;
   logic              trig_ev;
   logic [ADDR_W-1:0] pre_eff;
   logic [ADDR_W-1:0] post_rem;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      pre_len_d    = pre_len_q;
      post_cnt_d   = post_cnt_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;

      // FILL only writes (and checks triggers) while history is still short;
      // with a zero-length history it is a single idle cycle.
      fill_open = (cnt_q != pre_len_q);
      we = sample_en && !abort &&
           ((state_q == FILL && fill_open) || state_q == WAIT_TRIG || state_q == POST);
      trig_ev = (state_q == WAIT_TRIG && (trigger_detected || trig_force)) ||
                (state_q == FILL && fill_open && trig_force);
      pre_eff = (state_q == FILL) ? cnt_q : pre_len_q;

      // The write landing in the trigger cycle is the first post-trigger sample.
      post_rem = {ADDR_W{1'b1}} - pre_eff;
      if (we && post_rem != '0)
         post_rem = post_rem - ADDR_W'(1);

      if (we)
         ptr_d = ptr_q + ADDR_W'(1);

      if (abort) begin
         state_d = IDLE;
      end else if (trig_ev) begin
         trig_addr_d  = ptr_q - ADDR_W'(1);
         start_addr_d = ptr_q - ADDR_W'(1) - pre_eff;
         post_cnt_d   = post_rem;
         state_d      = (post_rem == '0) ? DONE : POST;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (arm) begin
                  pre_len_d  = pretrig_len;
                  ptr_d      = '0;
                  cnt_d      = '0;
                  post_cnt_d = '0;
                  state_d    = FILL;
               end
            end
            FILL: begin
               if (we)
                  cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_d == pre_len_q)
                  state_d = WAIT_TRIG;
            end
            POST: begin
               if (post_cnt_q == '0) begin
                  state_d = DONE;
               end else if (we) begin
                  post_cnt_d = post_cnt_q - ADDR_W'(1);
                  if (post_cnt_d == '0)
                     state_d = DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         pre_len_q    <= '0;
         post_cnt_q   <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         pre_len_q    <= pre_len_d;
         post_cnt_q   <= post_cnt_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
      end
   end

   assign mem_we     = we;
   assign mem_waddr  = ptr_q;
   assign mem_wdata  = data;
   assign busy       = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
   assign done       = (state_q == DONE);
   assign trig_addr  = trig_addr_q;
   assign start_addr = start_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl (ADDR_W=4): per-cycle write expectations and
// capture-complete addresses are queued by the driver and checked by a monitor.
module tb_capture_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       sample_en, trigger_detected, trig_force, arm, abort;
   logic [7:0] data;
   logic [3:0] pretrig_len;
   logic       mem_we;
   logic [3:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic       busy, done;
   logic [3:0] trig_addr, start_addr;

   capture_ctrl #(.ADDR_W(4)) dut (
      .clk(clk), .resetn(resetn), .sample_en(sample_en), .data(data),
      .trigger_detected(trigger_detected), .trig_force(trig_force),
      .arm(arm), .abort(abort), .pretrig_len(pretrig_len),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .trig_addr(trig_addr), .start_addr(start_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       we;
      logic [3:0] addr;
      logic [7:0] data;
   } wr_exp_t;

   typedef struct packed {
      logic [3:0] trig;
      logic [3:0] start;
   } done_exp_t;

   wr_exp_t   wq[$];
   done_exp_t dq[$];
   int        n_cmp = 0;
   int        n_bad = 0;
   logic      done_prev = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // One clock of stimulus; called just after a rising edge.
   task automatic cyc(input logic rn, input logic se, input logic td, input logic tf,
                      input logic ar, input logic ab, input logic we_e, input logic [3:0] a_e);
      wr_exp_t e;
      resetn = rn; sample_en = se; trigger_detected = td; trig_force = tf;
      arm = ar; abort = ab; data = 8'($urandom);
      e.we = we_e; e.addr = a_e; e.data = data;
      wq.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [3:0] a);
      cyc(1, 1, 0, 0, 0, 0, 1, a);
   endtask

   task automatic nw(input logic se);
      cyc(1, se, 0, 0, 0, 0, 0, 4'd0);
   endtask

   always @(negedge clk) begin
      wr_exp_t   e;
      done_exp_t d;
      if (wq.size() > 0) begin
         e = wq.pop_front();
         check("mem_we", 32'(mem_we), 32'(e.we));
         if (e.we) begin
            check("mem_waddr", 32'(mem_waddr), 32'(e.addr));
            check("mem_wdata", 32'(mem_wdata), 32'(e.data));
         end
      end
      if (done && !done_prev) begin
         if (dq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected: got done=1 expected no completion");
         end else begin
            d = dq.pop_front();
            check("trig_addr", 32'(trig_addr), 32'(d.trig));
            check("start_addr", 32'(start_addr), 32'(d.start));
         end
      end
      done_prev <= done;
   end

   initial begin
      resetn = 1'b0; sample_en = 1'b0; trigger_detected = 1'b0; trig_force = 1'b0;
      arm = 1'b0; abort = 1'b0; data = 8'd0; pretrig_len = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_we", 32'(mem_we), 0);
      check("rst_waddr", 32'(mem_waddr), 0);

      // Pre-trigger 3, trigger flag follows the 6th WAIT_TRIG write.
      pretrig_len = 4'd3;
      dq.push_back('{trig: 4'd8, start: 4'd5});
      cyc(1, 1, 0, 0, 1, 0, 0, 4'd0);
      for (int i = 0; i <= 8; i++) wr(4'(i));
      cyc(1, 1, 1, 0, 0, 0, 1, 4'd9);
      for (int i = 10; i <= 20; i++) wr(4'(i));
      nw(1); nw(1);
      check("s1_done", 32'(done), 1);
      check("s1_busy", 32'(busy), 0);

      // Zero history, trigger already high.
      pretrig_len = 4'd0;
      dq.push_back('{trig: 4'd15, start: 4'd15});
      cyc(1, 1, 1, 0, 1, 0, 0, 4'd0);
      cyc(1, 1, 1, 0, 0, 0, 0, 4'd0);
      for (int i = 0; i <= 14; i++) cyc(1, 1, 1, 0, 0, 0, 1, 4'(i));
      nw(1); nw(1);
      check("s2_done", 32'(done), 1);

      // Full history, pointer wraps, no post samples.
      pretrig_len = 4'd15;
      dq.push_back('{trig: 4'd15, start: 4'd0});
      cyc(1, 1, 0, 0, 1, 0, 0, 4'd0);
      for (int i = 0; i <= 15; i++) wr(4'(i));
      check("s3_wrap_ptr", 32'(mem_waddr), 0);
      cyc(1, 0, 1, 0, 0, 0, 0, 4'd0);
      check("s3_done_next", 32'(done), 1);
      nw(1); nw(1);

      // Detected trigger ignored in FILL, forced trigger after 2 writes; arm in POST ignored.
      pretrig_len = 4'd5;
      dq.push_back('{trig: 4'd1, start: 4'd15});
      cyc(1, 1, 0, 0, 1, 0, 0, 4'd0);
      cyc(1, 1, 1, 0, 0, 0, 1, 4'd0);
      cyc(1, 1, 1, 0, 0, 0, 1, 4'd1);
      cyc(1, 1, 0, 1, 0, 0, 1, 4'd2);
      for (int i = 3; i <= 14; i++) cyc(1, 1, 0, 0, (i == 5), 0, 1, 4'(i));
      nw(1); nw(1);
      check("s4_done", 32'(done), 1);

      // Abort together with arm mid-POST, then a clean restart.
      pretrig_len = 4'd2;
      cyc(1, 1, 0, 0, 1, 0, 0, 4'd0);
      wr(4'd0); wr(4'd1);
      cyc(1, 1, 1, 0, 0, 0, 1, 4'd2);
      wr(4'd3); wr(4'd4); wr(4'd5);
      cyc(1, 1, 0, 0, 1, 1, 0, 4'd0);
      check("s5_abort_done", 32'(done), 0);
      check("s5_abort_busy", 32'(busy), 0);
      nw(1); nw(1);
      pretrig_len = 4'd1;
      cyc(1, 1, 0, 0, 1, 0, 0, 4'd0);
      check("s5_restart_addr", 32'(mem_waddr), 0);
      wr(4'd0);
      cyc(1, 1, 0, 0, 0, 1, 0, 4'd0);

      // Sparse sampling, reset while waiting for the trigger.
      pretrig_len = 4'd2;
      cyc(1, 0, 0, 0, 1, 0, 0, 4'd0);
      wr(4'd0); nw(0); nw(0); nw(0);
      wr(4'd1); nw(0); nw(0); nw(0);
      wr(4'd2); nw(0);
      check("s6_wait_busy", 32'(busy), 1);
      cyc(0, 1, 0, 0, 0, 0, 0, 4'd0);
      check("s6_rst_busy", 32'(busy), 0);
      check("s6_rst_done", 32'(done), 0);
      check("s6_rst_trig", 32'(trig_addr), 0);
      check("s6_rst_start", 32'(start_addr), 0);
      check("s6_rst_waddr", 32'(mem_waddr), 0);
      check("s6_rst_we", 32'(mem_we), 0);
      nw(1);
      cyc(1, 1, 0, 0, 1, 0, 0, 4'd0);
      wr(4'd0); wr(4'd1);
      cyc(1, 1, 0, 0, 0, 1, 0, 4'd0);
      nw(1); nw(0);

      check("wq_drained", 32'(wq.size()), 0);
      check("dq_drained", 32'(dq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
